// File: rtl/regfile_read_stage.sv
// 31 x WIDTH register file (ZERO_REG reads 0) with a valid/ready read port and a write-first bypass.
// Reads have one-cycle latency. rd_ready = !out_valid || out_ready; held results track writes to their address.
module regfile_read_stage #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b
);

  localparam logic [4:0]  ZR      = 5'(ZERO_REG);
  localparam logic [31:0] ZR_MASK = 32'd1 << ZR;

  logic [WIDTH-1:0] regs_q [32];
  logic [31:0]      wr_dec;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_a_q, data_a_d;
  logic [WIDTH-1:0] data_b_q, data_b_d;
  logic [4:0]       addr_a_q, addr_a_d;
  logic [4:0]       addr_b_q, addr_b_d;

  logic             accept;
  logic             hold;
  logic [WIDTH-1:0] rd_val_a, rd_val_b;

  // The ZERO_REG slot is never written, so it stays a constant zero and trims away.
  assign wr_dec = write_en ? ((32'd1 << wr_addr) & ~ZR_MASK) : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_dec[i]) regs_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_val_a = regs_q[rd_addr_a];
    if (rd_addr_a == ZR)                           rd_val_a = '0;
    else if (write_en && (wr_addr == rd_addr_a))   rd_val_a = wr_data;

    rd_val_b = regs_q[rd_addr_b];
    if (rd_addr_b == ZR)                           rd_val_b = '0;
    else if (write_en && (wr_addr == rd_addr_b))   rd_val_b = wr_data;
  end

  assign rd_ready = !out_valid_q || out_ready;
  assign accept   = rd_valid && rd_ready;
  assign hold     = out_valid_q && !out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_a_d    = rd_val_a;
      data_b_d    = rd_val_b;
      addr_a_d    = rd_addr_a;
      addr_b_d    = rd_addr_b;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (hold) begin
      // Keep a stalled result coherent with writes to the register it came from.
      if (write_en && (wr_addr == addr_a_q) && (addr_a_q != ZR)) data_a_d = wr_data;
      if (write_en && (wr_addr == addr_b_q) && (addr_b_q != ZR)) data_b_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: writes, bypass, zero register, hold coherence, streaming, reset.
module tb_regfile_read_stage;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic             write_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [4:0]       rd_addr_a;
  logic [4:0]       rd_addr_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;

  int checks   = 0;
  int failures = 0;

  regfile_read_stage #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .write_en  (write_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_a    (data_a),
    .data_b    (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_valid  = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [WIDTH-1:0] d);
    write_en = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_valid  = 1'b1;
    rd_addr_a = a;
    rd_addr_b = b;
  endtask

  logic [WIDTH-1:0] stream_exp [4];

  initial begin
    idle();
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_data_a",    data_a, 64'd0);
    chk("reset_rd_ready",  {63'd0, rd_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Basic write then read, port b on the zero register
    wr(5'd5, 64'h1234);
    step();
    idle();
    rd(5'd5, 5'd31);
    step();
    chk("x5_data_a",    data_a, 64'h1234);
    chk("x5_data_b",    data_b, 64'd0);
    chk("x5_out_valid", {63'd0, out_valid}, 64'd1);

    // Same-cycle write-first bypass
    idle();
    wr(5'd7, 64'hAAAA);
    rd(5'd7, 5'd5);
    step();
    chk("bypass_data_a", data_a, 64'hAAAA);
    chk("bypass_data_b", data_b, 64'h1234);
    idle();
    rd(5'd7, 5'd0);
    step();
    chk("x7_later_a",    data_a, 64'hAAAA);
    chk("x0_unwritten_b", data_b, 64'd0);

    // Zero register: writes ignored, reads 0 even with same-cycle write
    idle();
    wr(5'd31, 64'hFFFF);
    step();
    idle();
    rd(5'd31, 5'd31);
    step();
    chk("zr_read_a", data_a, 64'd0);
    chk("zr_read_b", data_b, 64'd0);
    idle();
    wr(5'd31, 64'hFFFF);
    rd(5'd31, 5'd5);
    step();
    chk("zr_same_cycle_a", data_a, 64'd0);
    chk("zr_same_cycle_b", data_b, 64'h1234);
    idle();
    rd(5'd5, 5'd7);
    step();
    chk("zr_no_side_x5", data_a, 64'h1234);
    chk("zr_no_side_x7", data_b, 64'hAAAA);

    // Drain: out_valid clears, data holds
    idle();
    step();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_data_a",    data_a, 64'h1234);

    // Hold coherence on both ports
    wr(5'd3, 64'h10);
    step();
    idle();
    out_ready = 1'b0;
    rd(5'd3, 5'd3);
    step();
    chk("hold_a_init",   data_a, 64'h10);
    chk("hold_b_init",   data_b, 64'h10);
    chk("hold_rd_ready", {63'd0, rd_ready}, 64'd0);
    idle();
    wr(5'd3, 64'h20);
    rd(5'd1, 5'd2);
    step();
    chk("coh_a",         data_a, 64'h20);
    chk("coh_b",         data_b, 64'h20);
    chk("coh_out_valid", {63'd0, out_valid}, 64'd1);
    chk("coh_rd_ready",  {63'd0, rd_ready}, 64'd0);
    idle();
    wr(5'd5, 64'h99);
    step();
    chk("hold_stable_a", data_a, 64'h20);
    chk("hold_stable_b", data_b, 64'h20);
    idle();
    out_ready = 1'b1;
    #1;
    chk("release_rd_ready", {63'd0, rd_ready}, 64'd1);
    step();
    chk("release_drained", {63'd0, out_valid}, 64'd0);

    // Per-port independence: a zero-register port is not refreshed
    out_ready = 1'b0;
    rd(5'd3, 5'd31);
    step();
    idle();
    wr(5'd3, 64'h30);
    step();
    chk("indep_a", data_a, 64'h30);
    chk("indep_b", data_b, 64'd0);
    idle();
    wr(5'd31, 64'h77);
    step();
    chk("indep_zr_b", data_b, 64'd0);
    idle();
    out_ready = 1'b1;
    step();

    // Streaming with no bubbles: X1..X4
    wr(5'd1, 64'h11);
    step();
    wr(5'd2, 64'h22);
    step();
    wr(5'd4, 64'h44);
    step();
    idle();
    stream_exp[0] = 64'h11;
    stream_exp[1] = 64'h22;
    stream_exp[2] = 64'h30;
    stream_exp[3] = 64'h44;
    for (int i = 0; i < 4; i++) begin
      rd(5'(i + 1), 5'd31);
      step();
      chk($sformatf("stream%0d_data_a", i + 1), data_a, stream_exp[i]);
      chk($sformatf("stream%0d_valid", i + 1), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stream%0d_rd_ready", i + 1), {63'd0, rd_ready}, 64'd1);
    end
    idle();
    step();

    // Reset mid-hold
    wr(5'd9, 64'h55);
    step();
    idle();
    out_ready = 1'b0;
    rd(5'd9, 5'd9);
    step();
    chk("pre_reset_a", data_a, 64'h55);
    idle();
    wr(5'd10, 64'hBEEF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_data_a",    data_a, 64'd0);
    chk("async_rd_ready",  {63'd0, rd_ready}, 64'd1);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    out_ready = 1'b1;
    rd(5'd9, 5'd10);
    step();
    chk("post_reset_x9",    data_a, 64'd0);
    chk("post_reset_x10",   data_b, 64'd0);
    chk("post_reset_valid", {63'd0, out_valid}, 64'd1);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
